// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: one-hot execution codes, opcode/funct encodings,
// ALU commands, HALT encoding and the instruction-match helper.
package cpu_defs_pkg;

  localparam int EXE_W = 12;
  typedef logic [EXE_W-1:0] exe_t;

  localparam exe_t EXE_LW   = 12'h001;
  localparam exe_t EXE_SLLI = 12'h002;
  localparam exe_t EXE_SW   = 12'h004;
  localparam exe_t EXE_BEQ  = 12'h008;
  localparam exe_t EXE_ADD  = 12'h010;
  localparam exe_t EXE_SUB  = 12'h020;
  localparam exe_t EXE_SLL  = 12'h040;
  localparam exe_t EXE_XOR  = 12'h080;
  localparam exe_t EXE_OR   = 12'h100;
  localparam exe_t EXE_JAL  = 12'h200;
  localparam exe_t EXE_HALT = 12'h400;
  localparam exe_t EXE_AND  = 12'h800;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_LW     = 3'b010;
  localparam logic [2:0] F3_SW     = 3'b010;
  localparam logic [2:0] F3_SLLI   = 3'b001;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] HALT_INST = 32'h00100073;

  localparam logic [3:0] ALU_CMD_ADD  = 4'd0;
  localparam logic [3:0] ALU_CMD_SUB  = 4'd1;
  localparam logic [3:0] ALU_CMD_SLL  = 4'd2;
  localparam logic [3:0] ALU_CMD_XOR  = 4'd3;
  localparam logic [3:0] ALU_CMD_OR   = 4'd4;
  localparam logic [3:0] ALU_CMD_AND  = 4'd5;
  localparam logic [3:0] ALU_CMD_PASS = 4'd6;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADED  = 2'd1,
    ST_DECODED = 2'd2
  } dec_state_t;

  // Returns the one-hot execution code, or zero when nothing matches.
  function automatic exe_t decode_exec(input logic [31:0] ir);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    exe_t       e;
    opc = ir[6:0];
    f3  = ir[14:12];
    f7  = ir[31:25];
    e   = '0;
    if (ir == HALT_INST) begin
      e = EXE_HALT;
    end else begin
      case (opc)
        OPC_LOAD:   if (f3 == F3_LW) e = EXE_LW;
        OPC_OPIMM:  if (f3 == F3_SLLI && ir[31:26] == 6'b0) e = EXE_SLLI;
        OPC_STORE:  if (f3 == F3_SW) e = EXE_SW;
        OPC_BRANCH: if (f3 == F3_BEQ) e = EXE_BEQ;
        OPC_JAL:    e = EXE_JAL;
        OPC_OP: begin
          case ({f7, f3})
            {F7_BASE, F3_ADDSUB}: e = EXE_ADD;
            {F7_ALT,  F3_ADDSUB}: e = EXE_SUB;
            {F7_BASE, F3_SLL}:    e = EXE_SLL;
            {F7_BASE, F3_XOR}:    e = EXE_XOR;
            {F7_BASE, F3_OR}:     e = EXE_OR;
            {F7_BASE, F3_AND}:    e = EXE_AND;
            default:              e = '0;
          endcase
        end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/inst_decoder_if.sv
// Control <-> instruction decoder bus. Control (master) drives load/decode
// strobes and the ROM word; the decoder (slave) returns the registered decode.
interface inst_decoder_if #(
  parameter int CNT_W = 16
);
  import cpu_defs_pkg::*;

  // Handshake: load_inst is a level (IR captures every cycle it is high while
  // dec_en is low); dec_en is edge-qualified, only a 0->1 step requests a decode.
  // dec_valid answers the request one cycle later and stays high until the next load.
  logic             load_inst;
  logic             dec_en;
  logic [31:0]      inst_in;
  exe_t             execution;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [31:0]      ALU_data2;
  logic [31:0]      branch_offset;
  logic [31:0]      jump_offset;
  logic             dec_valid;
  logic             illegal;
  logic [CNT_W-1:0] inst_count;
  dec_state_t       state;

  modport master (
    output load_inst, dec_en, inst_in,
    input  execution, rs1, rs2, rd, ALU_data2, branch_offset, jump_offset,
           dec_valid, illegal, inst_count, state
  );

  modport slave (
    input  load_inst, dec_en, inst_in,
    output execution, rs1, rs2, rd, ALU_data2, branch_offset, jump_offset,
           dec_valid, illegal, inst_count, state
  );
endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator: ALU immediate for LW/SW/SLLI and the
// always-computed branch and jump byte offsets.
module imm_gen
  import cpu_defs_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] ALU_data2,
  output logic [31:0] branch_offset,
  output logic [31:0] jump_offset
);

  exe_t exe;

  assign exe = decode_exec(ir);

  always_comb begin
    ALU_data2 = '0;
    if (exe == EXE_LW)
      ALU_data2 = {{20{ir[31]}}, ir[31:20]};
    else if (exe == EXE_SW)
      ALU_data2 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    else if (exe == EXE_SLLI)
      ALU_data2 = {26'b0, ir[25:20]};
  end

  assign branch_offset = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign jump_offset   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

endmodule

// File: rtl/inst_decoder.sv
// Instruction register plus registered decoder. A three-state FSM tracks whether
// the IR is empty, freshly loaded, or already decoded; outputs hold until the next decode.
module inst_decoder
  import cpu_defs_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  inst_decoder_if.slave bus
);

  dec_state_t       state_q, state_d;
  logic [31:0]      ir_q;
  logic             dec_en_q;
  logic             dec_rise;
  logic             load_ir;
  logic             do_decode;
  logic             do_empty_dec;
  logic             clr_valid;
  exe_t             exe_d, exe_q;
  logic [31:0]      alu_d, br_d, jmp_d;
  logic [31:0]      alu_q, br_q, jmp_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic             valid_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  // dec_rise implies dec_en=1, so a simultaneous load is suppressed and the
  // decode sees the old IR.
  assign dec_rise = bus.dec_en & ~dec_en_q;
  assign load_ir  = bus.load_inst & ~bus.dec_en;
  assign exe_d    = decode_exec(ir_q);

  imm_gen u_imm_gen (
    .ir            (ir_q),
    .ALU_data2     (alu_d),
    .branch_offset (br_d),
    .jump_offset   (jmp_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      ir_q     <= '0;
      dec_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dec_en_q <= bus.dec_en;
      if (load_ir) ir_q <= bus.inst_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY:   if (load_ir)  state_d = ST_LOADED;
      ST_LOADED:  if (dec_rise) state_d = ST_DECODED;
      ST_DECODED: if (load_ir)  state_d = ST_LOADED;
      default:    state_d = ST_EMPTY;
    endcase
  end

  // A rise in DECODED is a re-decode of the same IR and deliberately does nothing.
  always_comb begin
    do_decode    = 1'b0;
    do_empty_dec = 1'b0;
    clr_valid    = 1'b0;
    case (state_q)
      ST_EMPTY:   do_empty_dec = dec_rise;
      ST_LOADED:  do_decode    = dec_rise;
      ST_DECODED: clr_valid    = load_ir;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      alu_q     <= '0;
      br_q      <= '0;
      jmp_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else if (do_decode) begin
      exe_q     <= exe_d;
      rs1_q     <= ir_q[19:15];
      rs2_q     <= ir_q[24:20];
      rd_q      <= ir_q[11:7];
      alu_q     <= alu_d;
      br_q      <= br_d;
      jmp_q     <= jmp_d;
      valid_q   <= 1'b1;
      illegal_q <= (exe_d == '0);
      if (exe_d != '0) cnt_q <= cnt_q + CNT_W'(1);
    end else if (do_empty_dec) begin
      exe_q     <= '0;
      illegal_q <= 1'b1;
    end else if (clr_valid) begin
      valid_q   <= 1'b0;
    end
  end

  assign bus.execution     = exe_q;
  assign bus.rs1           = rs1_q;
  assign bus.rs2           = rs2_q;
  assign bus.rd            = rd_q;
  assign bus.ALU_data2     = alu_q;
  assign bus.branch_offset = br_q;
  assign bus.jump_offset   = jmp_q;
  assign bus.dec_valid     = valid_q;
  assign bus.illegal       = illegal_q;
  assign bus.inst_count    = cnt_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_inst_decoder.sv
// Directed bench for inst_decoder: hand-computed vectors per feature, with a
// narrow counter so the wrap boundary is reachable quickly.
module tb_inst_decoder;
  import cpu_defs_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_decoder_if #(.CNT_W(CNT_W)) bus ();

  inst_decoder #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic [11:0]      exp_q[$];

  typedef struct {
    logic [31:0] inst;
    logic [11:0] exe;
    logic [31:0] alu;
    logic        ill;
  } vec_t;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.load_inst = 1'b0; bus.dec_en = 1'b0; bus.inst_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic load_ir(input logic [31:0] w);
    bus.load_inst = 1'b1; bus.inst_in = w;
    @(negedge clk);
    bus.load_inst = 1'b0;
  endtask

  task automatic pulse_dec();
    bus.dec_en = 1'b1;
    @(negedge clk);
    bus.dec_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic ld_dec(input logic [31:0] w, input logic legal);
    load_ir(w);
    pulse_dec();
    if (legal) exp_cnt = exp_cnt + CNT_W'(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.execution !== 12'h000) begin n_err++; $display("FAIL reset_exec: got %h want 000", bus.execution); end
    n_vec++; if ({bus.rs1, bus.rs2, bus.rd} !== 15'h0) begin n_err++; $display("FAIL reset_regs: got %h want 0", {bus.rs1, bus.rs2, bus.rd}); end
    n_vec++; if ({bus.ALU_data2, bus.branch_offset, bus.jump_offset} !== 96'h0) begin n_err++; $display("FAIL reset_imms: got %h want 0", {bus.ALU_data2, bus.branch_offset, bus.jump_offset}); end
    n_vec++; if ({bus.dec_valid, bus.illegal} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {bus.dec_valid, bus.illegal}); end
    n_vec++; if (bus.inst_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.inst_count); end
    n_vec++; if (bus.state !== ST_EMPTY) begin n_err++; $display("FAIL reset_state: got %0d want %0d", bus.state, ST_EMPTY); end
  endtask

  task automatic test_add();
    ld_dec(32'h002081B3, 1'b1);
    n_vec++; if (bus.execution !== 12'h010) begin n_err++; $display("FAIL add_exec: got %h want 010", bus.execution); end
    n_vec++; if ({bus.rs1, bus.rs2, bus.rd} !== {5'd1, 5'd2, 5'd3}) begin n_err++; $display("FAIL add_regs: got %0d %0d %0d want 1 2 3", bus.rs1, bus.rs2, bus.rd); end
    n_vec++; if ({bus.dec_valid, bus.illegal} !== 2'b10) begin n_err++; $display("FAIL add_flags: got %b want 10", {bus.dec_valid, bus.illegal}); end
    n_vec++; if (bus.inst_count !== CNT_W'(1)) begin n_err++; $display("FAIL add_count: got %0d want 1", bus.inst_count); end
  endtask

  task automatic test_imm();
    ld_dec(32'hFFC0A283, 1'b1);
    n_vec++; if (bus.execution !== 12'h001) begin n_err++; $display("FAIL lw_exec: got %h want 001", bus.execution); end
    n_vec++; if (bus.ALU_data2 !== 32'hFFFFFFFC) begin n_err++; $display("FAIL lw_imm: got %h want FFFFFFFC", bus.ALU_data2); end
    n_vec++; if ({bus.rs1, bus.rd} !== {5'd1, 5'd5}) begin n_err++; $display("FAIL lw_regs: got rs1=%0d rd=%0d want 1 5", bus.rs1, bus.rd); end
    ld_dec(32'hFE208CE3, 1'b1);
    n_vec++; if (bus.execution !== 12'h008) begin n_err++; $display("FAIL beq_exec: got %h want 008", bus.execution); end
    n_vec++; if (bus.branch_offset !== 32'hFFFFFFF8) begin n_err++; $display("FAIL beq_off: got %h want FFFFFFF8", bus.branch_offset); end
    n_vec++; if (bus.ALU_data2 !== 32'h0) begin n_err++; $display("FAIL beq_alu: got %h want 0", bus.ALU_data2); end
    ld_dec(32'h010000EF, 1'b1);
    n_vec++; if (bus.execution !== 12'h200) begin n_err++; $display("FAIL jal_exec: got %h want 200", bus.execution); end
    n_vec++; if (bus.jump_offset !== 32'h00000010) begin n_err++; $display("FAIL jal_off: got %h want 00000010", bus.jump_offset); end
    n_vec++; if (bus.rd !== 5'd1) begin n_err++; $display("FAIL jal_rd: got %0d want 1", bus.rd); end
  endtask

  task automatic test_ops();
    vec_t tbl[6];
    tbl[0] = '{32'h00331293, 12'h002, 32'h00000003, 1'b0};
    tbl[1] = '{32'hFE20AE23, 12'h004, 32'hFFFFFFFC, 1'b0};
    tbl[2] = '{32'h40331293, 12'h000, 32'h00000000, 1'b1};
    tbl[3] = '{32'h402091B3, 12'h000, 32'h00000000, 1'b1};
    tbl[4] = '{32'hFFC0B283, 12'h000, 32'h00000000, 1'b1};
    tbl[5] = '{32'h00100073, 12'h400, 32'h00000000, 1'b0};
    for (int i = 0; i < 6; i++) begin
      ld_dec(tbl[i].inst, ~tbl[i].ill);
      n_vec++; if (bus.execution !== tbl[i].exe) begin n_err++; $display("FAIL ops_exec[%0d]: got %h want %h", i, bus.execution, tbl[i].exe); end
      n_vec++; if (bus.ALU_data2 !== tbl[i].alu) begin n_err++; $display("FAIL ops_alu[%0d]: got %h want %h", i, bus.ALU_data2, tbl[i].alu); end
      n_vec++; if (bus.illegal !== tbl[i].ill) begin n_err++; $display("FAIL ops_illegal[%0d]: got %b want %b", i, bus.illegal, tbl[i].ill); end
      n_vec++; if (bus.inst_count !== exp_cnt) begin n_err++; $display("FAIL ops_count[%0d]: got %0d want %0d", i, bus.inst_count, exp_cnt); end
    end
  endtask

  task automatic test_illegal_clear();
    ld_dec(32'hFFFFFFFF, 1'b0);
    n_vec++; if ({bus.execution, bus.illegal, bus.dec_valid} !== {12'h000, 1'b1, 1'b1}) begin n_err++; $display("FAIL ill_flags: got exec=%h ill=%b val=%b want 000 1 1", bus.execution, bus.illegal, bus.dec_valid); end
    n_vec++; if (bus.rd !== 5'd31) begin n_err++; $display("FAIL ill_fields: got rd=%0d want 31", bus.rd); end
    n_vec++; if (bus.inst_count !== exp_cnt) begin n_err++; $display("FAIL ill_count: got %0d want %0d", bus.inst_count, exp_cnt); end
    ld_dec(32'h002081B3, 1'b1);
    n_vec++; if (bus.illegal !== 1'b0) begin n_err++; $display("FAIL ill_clear: got %b want 0", bus.illegal); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts[6];
    logic [11:0] exes[6];
    logic [11:0] got;
    insts = '{32'h002081B3, 32'h402081B3, 32'h002091B3, 32'h0020C1B3, 32'h0020E1B3, 32'h0020F1B3};
    exes  = '{12'h010, 12'h020, 12'h040, 12'h080, 12'h100, 12'h800};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exes[i]);
      ld_dec(insts[i], 1'b1);
      got = exp_q.pop_front();
      n_vec++; if (bus.execution !== got) begin n_err++; $display("FAIL b2b_exec[%0d]: got %h want %h", i, bus.execution, got); end
    end
    n_vec++; if (bus.inst_count !== exp_cnt) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", bus.inst_count, exp_cnt); end
  endtask

  task automatic test_held_dec();
    load_ir(32'h0020C1B3);
    bus.dec_en = 1'b1;
    repeat (3) @(negedge clk);
    bus.dec_en = 1'b0;
    @(negedge clk);
    exp_cnt = exp_cnt + CNT_W'(1);
    n_vec++; if (bus.inst_count !== exp_cnt) begin n_err++; $display("FAIL held_count: got %0d want %0d", bus.inst_count, exp_cnt); end
    n_vec++; if (bus.execution !== 12'h080) begin n_err++; $display("FAIL held_exec: got %h want 080", bus.execution); end
  endtask

  task automatic test_load_and_dec();
    load_ir(32'h402081B3);
    bus.load_inst = 1'b1; bus.inst_in = 32'h0020C1B3; bus.dec_en = 1'b1;
    @(negedge clk);
    bus.load_inst = 1'b0; bus.dec_en = 1'b0;
    @(negedge clk);
    exp_cnt = exp_cnt + CNT_W'(1);
    n_vec++; if (bus.execution !== 12'h020) begin n_err++; $display("FAIL simul_exec: got %h want 020", bus.execution); end
    pulse_dec();
    n_vec++; if ({bus.execution, bus.inst_count} !== {12'h020, exp_cnt}) begin n_err++; $display("FAIL redecode: got %h/%0d want 020/%0d", bus.execution, bus.inst_count, exp_cnt); end
    load_ir(32'h0020C1B3);
    n_vec++; if ({bus.dec_valid, bus.execution} !== {1'b0, 12'h020}) begin n_err++; $display("FAIL reload_hold: got %b/%h want 0/020", bus.dec_valid, bus.execution); end
    pulse_dec();
    exp_cnt = exp_cnt + CNT_W'(1);
    n_vec++; if ({bus.dec_valid, bus.execution} !== {1'b1, 12'h080}) begin n_err++; $display("FAIL reload_dec: got %b/%h want 1/080", bus.dec_valid, bus.execution); end
  endtask

  task automatic test_reset_decoded();
    ld_dec(32'h002081B3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    n_vec++; if ({bus.execution, bus.rs1, bus.rs2, bus.rd, bus.dec_valid, bus.illegal} !== 29'h0) begin n_err++; $display("FAIL rst_dec_outs: got exec=%h val=%b", bus.execution, bus.dec_valid); end
    n_vec++; if (bus.inst_count !== '0) begin n_err++; $display("FAIL rst_dec_count: got %0d want 0", bus.inst_count); end
  endtask

  task automatic test_empty_dec();
    pulse_dec();
    n_vec++; if ({bus.execution, bus.illegal, bus.dec_valid} !== {12'h000, 1'b1, 1'b0}) begin n_err++; $display("FAIL empty_dec: got %h %b %b want 000 1 0", bus.execution, bus.illegal, bus.dec_valid); end
    n_vec++; if (bus.state !== ST_EMPTY) begin n_err++; $display("FAIL empty_state: got %0d want %0d", bus.state, ST_EMPTY); end
    // dec_en held through reset must still count as a rise on the first free cycle
    @(negedge clk);
    rst = 1'b1; bus.dec_en = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.illegal !== 1'b0) begin n_err++; $display("FAIL rst_prio: got %b want 0", bus.illegal); end
    rst = 1'b0;
    @(negedge clk);
    bus.dec_en = 1'b0;
    n_vec++; if (bus.illegal !== 1'b1) begin n_err++; $display("FAIL first_rise: got %b want 1", bus.illegal); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) ld_dec(32'h002081B3, 1'b1);
    n_vec++; if (bus.inst_count !== CNT_W'(15)) begin n_err++; $display("FAIL wrap_pre: got %0d want 15", bus.inst_count); end
    ld_dec(32'h002081B3, 1'b1);
    n_vec++; if (bus.inst_count !== '0) begin n_err++; $display("FAIL wrap: got %0d want 0", bus.inst_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bus.load_inst = 1'b0; bus.dec_en = 1'b0; bus.inst_in = '0;
    exp_cnt = '0;
    test_reset();
    test_add();
    test_imm();
    test_ops();
    test_illegal_clear();
    test_back_to_back();
    test_held_dec();
    test_load_and_dec();
    test_reset_decoded();
    test_empty_dec();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
